// File: rtl/ex_div_if.sv
// ex_div_if -- connection bundle between the EX stage and the iterative divider.
//
// Signals:
//   div_start   EX -> div   EX holds a DIV/DIVU; stays high while the instruction is in EX
//   div_signed  EX -> div   1 = DIV (two's complement), 0 = DIVU
//   opdata1     EX -> div   32-bit dividend
//   opdata2     EX -> div   32-bit divisor
//   cancel      EX -> div   pipeline flush; aborts any division in flight
//   result_o    div -> EX   {remainder (HI), quotient (LO)}; zero unless ready_o is high
//   ready_o     div -> EX   one-cycle result-valid pulse
//   stallreq_o  div -> EX   stall request, forwarded as stallreq_from_ex
//
// Modports: master = EX stage side, slave = divider side.
interface ex_div_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        cancel;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output div_start, div_signed, opdata1, opdata2, cancel,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, cancel,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div -- iterative radix-2 restoring divider for the EX stage (DIV / DIVU).
//
// A division is latched in FREE, runs 32 iterations in ON and presents its
// result for exactly one cycle in END, 33 cycles after div_start first rose.
// While a division is pending (div_start high and not yet in END) the stall
// request is raised combinationally.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   div_bus  ex_div_if.slave: div_start, div_signed, opdata1, opdata2, cancel in;
//                             result_o ({rem, quo}), ready_o, stallreq_o out
//
// Build option:
//   DIV_ZERO_CHECK_EN  when defined, a zero divisor skips the iterations via the
//                      BY_ZERO state and returns result 0 in cycle 2. When not
//                      defined, a zero divisor runs all 32 iterations and yields
//                      quotient all-ones and remainder |dividend| before sign fix.
module ex_div (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div_bus
);

  localparam logic [1:0] FREE    = 2'b00;
`ifdef DIV_ZERO_CHECK_EN
  localparam logic [1:0] BY_ZERO = 2'b01;
`endif
  localparam logic [1:0] ON      = 2'b10;
  localparam logic [1:0] END     = 2'b11;

  logic [1:0]  state_reg;
  logic [4:0]  cnt_reg;
  // The partial remainder is always below the divisor (or, for a zero divisor,
  // holds only the dividend bits shifted in so far), so 32 stored bits suffice;
  // the 33rd bit appears only transiently after the shift.
  logic [31:0] rem_reg;
  // Holds the dividend magnitude; quotient bits shift in from the right as the
  // dividend bits shift out on the left.
  logic [31:0] quo_reg;
  logic [31:0] divisor_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [63:0] result_reg;
  logic        ready_reg;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;

  // Operand magnitudes; 0x80000000 negates to itself, which is its correct
  // unsigned magnitude.
  assign op1_abs = (div_bus.div_signed & div_bus.opdata1[31]) ? (32'd0 - div_bus.opdata1)
                                                              : div_bus.opdata1;
  assign op2_abs = (div_bus.div_signed & div_bus.opdata2[31]) ? (32'd0 - div_bus.opdata2)
                                                              : div_bus.opdata2;

  // One restoring step. When the trial subtraction fits, the true difference
  // is below the divisor, so the 32-bit wrap-around subtraction is exact.
  always_comb begin
    shifted   = {rem_reg, quo_reg[31]};
    fits      = (shifted >= {1'b0, divisor_reg});
    rem_next  = fits ? (shifted[31:0] - divisor_reg) : shifted[31:0];
    quo_next  = {quo_reg[30:0], fits};
    quo_fixed = neg_q_reg ? (32'd0 - quo_next) : quo_next;
    rem_fixed = neg_r_reg ? (32'd0 - rem_next) : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FREE;
      cnt_reg     <= 5'd0;
      rem_reg     <= 32'd0;
      quo_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= 64'd0;
      ready_reg   <= 1'b0;
    end else if (div_bus.cancel) begin
      state_reg  <= FREE;
      cnt_reg    <= 5'd0;
      result_reg <= 64'd0;
      ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FREE: begin
          result_reg <= 64'd0;
          ready_reg  <= 1'b0;
          if (div_bus.div_start) begin
            quo_reg     <= op1_abs;
            divisor_reg <= op2_abs;
            rem_reg     <= 32'd0;
            cnt_reg     <= 5'd0;
            neg_q_reg   <= div_bus.div_signed & (div_bus.opdata1[31] ^ div_bus.opdata2[31]);
            neg_r_reg   <= div_bus.div_signed & div_bus.opdata1[31];
`ifdef DIV_ZERO_CHECK_EN
            state_reg   <= (div_bus.opdata2 == 32'd0) ? BY_ZERO : ON;
`else
            state_reg   <= ON;
`endif
          end
        end
`ifdef DIV_ZERO_CHECK_EN
        BY_ZERO: begin
          result_reg <= 64'd0;
          ready_reg  <= 1'b1;
          state_reg  <= END;
        end
`endif
        ON: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            result_reg <= {rem_fixed, quo_fixed};
            ready_reg  <= 1'b1;
            state_reg  <= END;
          end
        end
        END: begin
          // Single result cycle; FREE next lets a following division start
          // even though div_start never dropped.
          result_reg <= 64'd0;
          ready_reg  <= 1'b0;
          state_reg  <= FREE;
        end
        default: begin
          result_reg <= 64'd0;
          ready_reg  <= 1'b0;
          state_reg  <= FREE;
        end
      endcase
    end
  end

  assign div_bus.result_o   = result_reg;
  assign div_bus.ready_o    = ready_reg;
  assign div_bus.stallreq_o = div_bus.div_start & (state_reg != END) & ~rst;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div -- self-checking bench for ex_div.
//
// Each cycle of a division, {stallreq_o, ready_o, result_o} is compared with
// an expectation built from the cycle index, the result latency and a
// plain-arithmetic reference quotient/remainder. Operands are scrambled after
// the start cycle to confirm they are latched.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_div_if div_bus ();

  ex_div dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (div_bus)
  );

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZERO_CHK = 1'b1;
`else
  localparam bit ZERO_CHK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] status();
    return {div_bus.stallreq_o, div_bus.ready_o, div_bus.result_o};
  endfunction

  // Reference: divide magnitudes with native arithmetic, then apply the sign
  // rules (quotient negated on differing signs, remainder follows dividend).
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (ZERO_CHK && b == 32'd0) return 64'd0;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  // Starts a division at the current negedge (cycle 0) and checks every cycle
  // up to the result. abort_kind 1 = cancel, 2 = reset, asserted in cycle abort_at.
  // Returns at the negedge of the cycle following the last one checked.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input int abort_kind, input string tag);
    logic [63:0] exp;
    int          lat;
    exp = model(s, a, b);
    lat = (ZERO_CHK && b == 32'd0) ? 2 : 33;
    div_bus.div_start  = 1'b1;
    div_bus.div_signed = s;
    div_bus.opdata1    = a;
    div_bus.opdata2    = b;
    for (int cyc = 0; cyc <= lat; cyc++) begin
      if (cyc > 0) begin
        div_bus.opdata1    = $urandom;
        div_bus.opdata2    = $urandom;
        div_bus.div_signed = 1'($urandom_range(0, 1));
      end
      if (cyc == abort_at) begin
        if (abort_kind == 1) div_bus.cancel = 1'b1;
        else rst = 1'b1;
        #1;
        check($sformatf("%s abort c%0d", tag, cyc), status(),
              (abort_kind == 1) ? {1'b1, 1'b0, 64'd0} : 66'd0);
        @(negedge clk);
        div_bus.cancel = 1'b0;
        if (abort_kind == 2) begin
          #1;
          check($sformatf("%s rst_held", tag), status(), 66'd0);
          @(negedge clk);
          rst = 1'b0;
        end
        $display("%s s=%0d %h/%h aborted kind %0d at cycle %0d", tag, s, a, b, abort_kind, abort_at);
        return;
      end
      #1;
      check($sformatf("%s c%0d", tag, cyc), status(),
            {(cyc < lat), (cyc == lat), (cyc == lat) ? exp : 64'd0});
      @(negedge clk);
    end
    $display("%s s=%0d %h/%h -> %h lat %0d", tag, s, a, b, exp, lat);
  endtask

  task automatic idle();
    div_bus.div_start = 1'b0;
    #1;
    check("idle", status(), 66'd0);
    @(negedge clk);
  endtask

  logic [31:0] ra, rb;
  logic        rs;
  logic [31:0] specials [4];

  initial begin
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;

    rst = 1'b1;
    div_bus.div_start  = 1'b0;
    div_bus.div_signed = 1'b0;
    div_bus.opdata1    = 32'd0;
    div_bus.opdata2    = 32'd0;
    div_bus.cancel     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset", status(), 66'd0);
    div_bus.div_start = 1'b1;
    #1;
    check("reset_stall_gate", status(), 66'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    run_div(1'b0, 32'd100, 32'd7, -1, 0, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, "div_m7_2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, "div_min_m1");
    idle();
    run_div(1'b0, 32'd9, 32'd3, -1, 0, "b2b_9_3");
    run_div(1'b0, 32'd10, 32'd4, -1, 0, "b2b_10_4");
    idle();
    run_div(1'b0, 32'd1000, 32'd3, 10, 1, "cancel");
    run_div(1'b0, 32'd123, 32'd4, -1, 0, "after_cancel");
    idle();
    run_div(1'b0, 32'd7, 32'd0, -1, 0, "divu_7_0");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd0, -1, 0, "div_m7_0");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 0, "div_7_m2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 0, "divu_max_1");
    idle();
    run_div(1'b0, 32'd5000, 32'd9, 15, 2, "rst_mid");
    idle();

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = specials[$urandom_range(0, 3)];
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) idle();
      run_div(rs, ra, rb, -1, 0, $sformatf("rand%0d", i));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit radix-2 divider for the EX stage of the five-stage pipeline. It implements DIV and DIVU in 32 iterations and returns remainder/quotient for HI/LO. While a division is in flight it raises a stall request that EX forwards to the pipeline controller as `stallreq_from_ex`. A flush cancels it at once.

## Interface
Parameters: none. Width is fixed at 32/64 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- div_start  input  1  EX holds a DIV/DIVU. Held high by EX for as long as the instruction stays in EX.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with the operands.
- opdata1  input  32  dividend.
- opdata2  input  32  divisor.
- cancel  input  1  flush. Abort any operation and return to FREE.
- result_o  output  64  [63:32] remainder (HI), [31:0] quotient (LO). Valid only while ready_o=1; 0 otherwise.
- ready_o  output  1  result valid. One-cycle pulse.
- stallreq_o  output  1  combinational stall request: div_start & (state != END) & ~rst.

## Operation
States: FREE, BY_ZERO, ON, END. Priority is rst > cancel > normal.

- **rst**: state=FREE, cnt=0, result_o=0, ready_o=0.
- **cancel=1 in any state**: on the next edge go to FREE with ready_o=0 and result_o=0. Partial results are discarded.
- **FREE**:
  - If div_start=0, stay in FREE.
  - If div_start=1, latch div_signed, opdata1 and opdata2.
  - If signed, convert each operand to its absolute value.
  - Clear the 33-bit partial remainder and cnt, then go to ON (or BY_ZERO, see Configuration).
  - Operand changes after this latch are ignored.
- **ON**: restoring step, once per edge.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set quotient bit 0.
  - cnt increments 0..31.
  - On the edge that completes iteration 32:
    - Apply sign correction: negate the quotient if the operand signs differ (signed only); give the remainder the sign of the dividend.
    - Load result_o, set ready_o=1, go to END.
- **END**: lasts exactly one cycle and returns unconditionally to FREE, with ready_o=0 and result_o=0. This lets a back-to-back DIV, with div_start still high, start cleanly from FREE.
- **Arithmetic**:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
  - |0x80000000| is treated as unsigned 0x80000000.

## Timing
- div_start first high in cycle 0 (FREE). ON covers cycles 1..32. ready_o=1 in cycle 33. The result is 33 cycles after start.
- stallreq_o is high in cycles 0..32 and low in cycle 33, so the instruction leaves EX at the end of cycle 33 carrying result_o.
- In cycle 34 the state is FREE. If the next instruction is also a division, stallreq_o rises combinationally in that cycle.
- cancel asserted in cycle k: the state is FREE in cycle k+1. stallreq_o follows div_start in that cycle; the flush normally drops it.
- Reset outputs: result_o=0, ready_o=0, stallreq_o=0.

## Configuration
`DIV_ZERO_CHECK_EN`:
- **Defined**: in FREE, if div_start=1 and opdata2=0, go to BY_ZERO. BY_ZERO goes to END on the next edge with result_o=0, so ready_o=1 in cycle 2.
- **Undefined**: the BY_ZERO state is absent. A zero divisor runs all 32 iterations:
  - Raw quotient 0xFFFFFFFF and raw remainder |dividend|, then normal sign correction.
  - DIVU 7/0 gives result_o = {0x00000007, 0xFFFFFFFF} in cycle 33.

## Test plan
- DIVU 100/7, div_start held from cycle 0 -> stallreq_o high in cycles 0..32; ready_o pulses in cycle 33 with result_o={0x00000002,0x0000000E}.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF,0xFFFFFFFD}. DIV 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}.
- Two back-to-back DIVU 9/3 then 10/4 with div_start continuously high -> first ready in cycle 33 {0,3}; second starts in cycle 34, ready in cycle 67 {2,2}.
- cancel=1 in cycle 10 of a division -> FREE in cycle 11, ready_o stays 0, and a new start in cycle 11 completes normally in cycle 44.
- Divisor 0, DIVU 7/0 -> with `DIV_ZERO_CHECK_EN`, ready_o in cycle 2 with result_o=0; without it, ready_o in cycle 33 with {0x00000007,0xFFFFFFFF}.
- rst asserted in cycle 15 mid-operation -> next cycle state=FREE, all outputs 0, and stallreq_o=0 while rst is held.
